// File: rtl/i2c_burst_writer.sv
// Open-drain I2C write master: START, address+W, register bytes, data bytes, STOP, ACK checked per byte.
// Optional slave clock stretching is compiled in with I2C_CLK_STRETCH_EN.
module i2c_burst_writer #(
    parameter int REG_BYTES  = 1,
    parameter int DATA_BYTES = 1,
    parameter int CLK_DIV    = 1
) (
    input  logic                    CLK,
    input  logic                    RESET_N,
    input  logic                    START,
    input  logic [6:0]              DEV_ADDR,
    input  logic [8*REG_BYTES-1:0]  REG_ADDR,
    input  logic [8*DATA_BYTES-1:0] DATA,
    input  logic                    I2C_SDA_IN,
    input  logic                    I2C_SCL_IN,
    output logic                    I2C_SDA_OE,
    output logic                    I2C_SCL_OE,
    output logic                    READY,
    output logic                    DONE,
    output logic                    ERROR,
    output logic [2:0]              NACK_IDX
);

    localparam int N  = 1 + REG_BYTES + DATA_BYTES;
    localparam int W  = 8 * N;
    localparam int QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {IDLE, STRT, BIT, ACK, STOP} state_t;

    state_t         state_q, state_d;
    logic [QW-1:0]  quarter_q;
    logic [1:0]     phase_q;
    logic [2:0]     bit_q;
    logic [2:0]     byte_q;
    logic [W-1:0]   shift_q;
    logic           error_q;
    logic [2:0]     nack_idx_q;
    logic           done_q;

    logic           scl_oe, sda_oe;
    logic           stall, tick, last_phase, phase_end, accept, sample, nack_now;

`ifdef I2C_CLK_STRETCH_EN
    assign stall = ((((state_q == BIT) || (state_q == ACK)) && (phase_q == 2'd2)) ||
                    ((state_q == STOP) && (phase_q == 2'd1))) && !scl_oe && !I2C_SCL_IN;
`else
    logic unused_scl_in;
    assign unused_scl_in = I2C_SCL_IN;
    assign stall = 1'b0;
`endif

    assign tick   = (quarter_q == QW'(CLK_DIV - 1)) && !stall;
    assign accept = (state_q == IDLE) && START;

    always_comb begin
        last_phase = 1'b0;
        case (state_q)
            STRT:      last_phase = (phase_q == 2'd1);
            BIT, ACK:  last_phase = (phase_q == 2'd3);
            STOP:      last_phase = (phase_q == 2'd2);
            default:   last_phase = 1'b0;
        endcase
    end

    assign phase_end = tick && last_phase;
    // ACK is sampled on the first clock of q3; with CLK_DIV=1 that is also the last clock of the slot.
    assign sample    = (state_q == ACK) && (phase_q == 2'd3) && (quarter_q == '0);
    assign nack_now  = sample && I2C_SDA_IN;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (START) state_d = STRT;
            STRT: if (phase_end) state_d = BIT;
            BIT:  if (phase_end && (bit_q == 3'd7)) state_d = ACK;
            ACK: begin
                if (phase_end) begin
                    if (error_q || nack_now || (byte_q == 3'(N - 1))) state_d = STOP;
                    else state_d = BIT;
                end
            end
            STOP: if (phase_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        scl_oe = 1'b0;
        sda_oe = 1'b0;
        case (state_q)
            STRT: sda_oe = (phase_q == 2'd1);
            BIT: begin
                scl_oe = (phase_q < 2'd2);
                sda_oe = ~shift_q[W-1];
            end
            ACK:  scl_oe = (phase_q < 2'd2);
            STOP: begin
                scl_oe = (phase_q == 2'd0);
                sda_oe = (phase_q != 2'd2);
            end
            default: begin
                scl_oe = 1'b0;
                sda_oe = 1'b0;
            end
        endcase
    end

    // Timing counters, frame shift register and NACK bookkeeping.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            quarter_q  <= '0;
            phase_q    <= 2'd0;
            bit_q      <= 3'd0;
            byte_q     <= 3'd0;
            shift_q    <= '0;
            error_q    <= 1'b0;
            nack_idx_q <= 3'd0;
            done_q     <= 1'b0;
        end else begin
            done_q <= (state_q == STOP) && phase_end;
            if (accept) begin
                quarter_q  <= '0;
                phase_q    <= 2'd0;
                bit_q      <= 3'd0;
                byte_q     <= 3'd0;
                shift_q    <= {DEV_ADDR, 1'b0, REG_ADDR, DATA};
                error_q    <= 1'b0;
                nack_idx_q <= 3'd0;
            end else if (state_q != IDLE) begin
                if (!stall) quarter_q <= tick ? '0 : quarter_q + 1'b1;
                if (tick) phase_q <= last_phase ? 2'd0 : phase_q + 2'd1;
                if (phase_end && (state_q == BIT)) begin
                    bit_q   <= bit_q + 3'd1;
                    shift_q <= shift_q << 1;
                end
                if (phase_end && (state_q == ACK)) byte_q <= byte_q + 3'd1;
                if (nack_now) begin
                    error_q    <= 1'b1;
                    nack_idx_q <= byte_q;
                end
            end
        end
    end

    assign I2C_SCL_OE = scl_oe;
    assign I2C_SDA_OE = sda_oe;
    assign READY      = (state_q == IDLE);
    assign DONE       = done_q;
    assign ERROR      = error_q;
    assign NACK_IDX   = nack_idx_q;

endmodule

// File: tb/tb_i2c_burst_writer.sv
// Self-checking bench for i2c_burst_writer: a default-parameter instance and a 2-reg/4-data CLK_DIV=4 instance,
// each with a behavioural slave that captures bytes and ACKs or NACKs a chosen byte.
module tb_i2c_burst_writer;

    logic CLK = 1'b0;
    logic rstN = 1'b0;
    always #5 CLK = ~CLK;

    logic        start0 = 1'b0, start1 = 1'b0;
    logic [6:0]  dev0 = '0, dev1 = '0;
    logic [7:0]  reg0 = '0;
    logic [15:0] reg1 = '0;
    logic [7:0]  dat0 = '0;
    logic [31:0] dat1 = '0;
    logic        stretch0 = 1'b0;
    wire  [1:0]  sclOe, sdaOe, sdaLine;
    logic [1:0]  drive = 2'b00;
    wire         sclIn0, sclIn1;
    wire         ready0, done0, error0, ready1, done1, error1;
    wire  [2:0]  nackIdx0, nackIdx1;

    assign sdaLine = ~sdaOe & ~drive;
    assign sclIn0  = ~sclOe[0] & ~stretch0;
    assign sclIn1  = ~sclOe[1];

    i2c_burst_writer dut0 (
        .CLK(CLK), .RESET_N(rstN), .START(start0), .DEV_ADDR(dev0), .REG_ADDR(reg0), .DATA(dat0),
        .I2C_SDA_IN(sdaLine[0]), .I2C_SCL_IN(sclIn0), .I2C_SDA_OE(sdaOe[0]), .I2C_SCL_OE(sclOe[0]),
        .READY(ready0), .DONE(done0), .ERROR(error0), .NACK_IDX(nackIdx0)
    );

    i2c_burst_writer #(.REG_BYTES(2), .DATA_BYTES(4), .CLK_DIV(4)) dut1 (
        .CLK(CLK), .RESET_N(rstN), .START(start1), .DEV_ADDR(dev1), .REG_ADDR(reg1), .DATA(dat1),
        .I2C_SDA_IN(sdaLine[1]), .I2C_SCL_IN(sclIn1), .I2C_SDA_OE(sdaOe[1]), .I2C_SCL_OE(sclOe[1]),
        .READY(ready1), .DONE(done1), .ERROR(error1), .NACK_IDX(nackIdx1)
    );

    // Behavioural slaves: detect START, shift bits on SCL rise, drive the ACK slot after each byte.
    int         bitCnt [2];
    int         byteCnt [2];
    int         nackSel [2];
    logic [7:0] shiftR [2];
    logic [7:0] cap [2][8];
    logic       prevScl [2];
    logic       prevSda [2];
    logic       monScl, monSda;

    initial begin
        for (int i = 0; i < 2; i++) begin
            bitCnt[i] = 0; byteCnt[i] = 0; nackSel[i] = -1;
            shiftR[i] = '0; prevScl[i] = 1'b1; prevSda[i] = 1'b1;
        end
    end

    always @(negedge CLK) begin
        for (int i = 0; i < 2; i++) begin
            monScl = ~sclOe[i];
            monSda = sdaLine[i];
            if (prevScl[i] && monScl && prevSda[i] && !monSda) begin
                bitCnt[i] = 0;
                byteCnt[i] = 0;
                drive[i] = 1'b0;
            end else if (!prevScl[i] && monScl) begin
                if (bitCnt[i] < 8) begin
                    shiftR[i] = {shiftR[i][6:0], monSda};
                    bitCnt[i] = bitCnt[i] + 1;
                    if (bitCnt[i] == 8) begin
                        if (byteCnt[i] < 8) cap[i][byteCnt[i]] = shiftR[i];
                        byteCnt[i] = byteCnt[i] + 1;
                    end
                end else begin
                    bitCnt[i] = 0;
                end
            end else if (prevScl[i] && !monScl) begin
                drive[i] = (bitCnt[i] == 8) && ((byteCnt[i] - 1) != nackSel[i]);
            end
            prevScl[i] = monScl;
            prevSda[i] = monSda;
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issues one request on dut0 and returns the cycle count from the accept cycle to the DONE cycle.
    task automatic applyStimulus(input logic [6:0] dev, input logic [7:0] r, input logic [7:0] d,
                                 input int nackAt, input int stretchAt, input bit hold, output int lat);
        @(negedge CLK);
        dev0 = dev; reg0 = r; dat0 = d; nackSel[0] = nackAt; start0 = 1'b1;
        lat = 0;
        do begin
            @(negedge CLK);
            lat++;
            if (!hold) start0 = 1'b0;
            stretch0 = (stretchAt >= 0) && (lat >= stretchAt) && (lat < stretchAt + 20);
            if (lat == 1) begin
                checkOutput("readyDrop", {31'b0, ready0}, 32'd0);
                checkOutput("errClear", {31'b0, error0}, 32'd0);
            end
        end while (!done0 && lat < 3000);
        stretch0 = 1'b0;
    endtask

    typedef struct {
        logic [6:0]  dev;
        logic [7:0]  regA;
        logic [7:0]  dat;
        int          nackAt;
        int          expBytes;
        logic [23:0] expStream;
        logic        expErr;
        logic [2:0]  expIdx;
        int          expLat;
    } vec_t;

    vec_t vecs [6];
    int   lat;
    logic prevErr;
    logic activity;
    logic [55:0] bigStream;

    initial begin
        vecs[0] = '{7'h1A, 8'h0F, 8'h55, -1, 3, 24'h340F55, 1'b0, 3'd0, 114};
        vecs[1] = '{7'h50, 8'hA5, 8'hC3, -1, 3, 24'hA0A5C3, 1'b0, 3'd0, 114};
        vecs[2] = '{7'h1A, 8'h0F, 8'h55,  2, 3, 24'h340F55, 1'b1, 3'd2, 114};
        vecs[3] = '{7'h7F, 8'h00, 8'hFF,  0, 1, 24'hFE0000, 1'b1, 3'd0,  42};
        vecs[4] = '{7'h01, 8'h80, 8'h01,  1, 2, 24'h028000, 1'b1, 3'd1,  78};
        vecs[5] = '{7'h2B, 8'h3C, 8'h4D, -1, 3, 24'h563C4D, 1'b0, 3'd0, 114};

        #1;
        checkOutput("rstReady", {31'b0, ready0}, 32'd1);
        checkOutput("rstSclOe", {31'b0, sclOe[0]}, 32'd0);
        checkOutput("rstSdaOe", {31'b0, sdaOe[0]}, 32'd0);
        checkOutput("rstDone", {31'b0, done0}, 32'd0);
        checkOutput("rstError", {31'b0, error0}, 32'd0);
        checkOutput("rstNackIdx", {29'b0, nackIdx0}, 32'd0);
        repeat (3) @(negedge CLK);
        rstN = 1'b1;
        repeat (3) @(negedge CLK);

        prevErr = 1'b0;
        for (int v = 0; v < 6; v++) begin
            checkOutput("errHold", {31'b0, error0}, {31'b0, prevErr});
            checkOutput("readyIdle", {31'b0, ready0}, 32'd1);
            applyStimulus(vecs[v].dev, vecs[v].regA, vecs[v].dat, vecs[v].nackAt, -1, 1'b0, lat);
            checkOutput($sformatf("latency%0d", v), lat, vecs[v].expLat);
            checkOutput($sformatf("readyAtDone%0d", v), {31'b0, ready0}, 32'd1);
            checkOutput($sformatf("error%0d", v), {31'b0, error0}, {31'b0, vecs[v].expErr});
            if (vecs[v].expErr)
                checkOutput($sformatf("nackIdx%0d", v), {29'b0, nackIdx0}, {29'b0, vecs[v].expIdx});
            checkOutput($sformatf("byteCount%0d", v), byteCnt[0], vecs[v].expBytes);
            for (int k = 0; k < vecs[v].expBytes; k++)
                checkOutput($sformatf("byte%0d_%0d", v, k), {24'b0, cap[0][k]},
                            {24'b0, vecs[v].expStream[23-8*k -: 8]});
            prevErr = vecs[v].expErr;
            repeat (2) @(negedge CLK);
        end

        // START held high: second frame is accepted in the DONE cycle of the first.
        applyStimulus(7'h1A, 8'h0F, 8'h55, -1, -1, 1'b1, lat);
        checkOutput("holdLat1", lat, 114);
        checkOutput("holdReadyAtDone", {31'b0, ready0}, 32'd1);
        @(negedge CLK);
        checkOutput("holdReadyDrop", {31'b0, ready0}, 32'd0);
        checkOutput("holdStrtQ0", {30'b0, sclOe[0], sdaOe[0]}, 32'd0);
        @(negedge CLK);
        checkOutput("holdStrtQ1", {30'b0, sclOe[0], sdaOe[0]}, 32'd1);
        lat = 2;
        while (!done0 && lat < 3000) begin
            @(negedge CLK);
            lat++;
        end
        start0 = 1'b0;
        checkOutput("holdLat2", lat, 114);
        checkOutput("holdBytes", byteCnt[0], 3);
        @(negedge CLK);
        checkOutput("holdIdleAfter", {31'b0, ready0}, 32'd1);

        // Wide instance, with a START pulse mid-frame that must be ignored.
        bigStream = 56'h341234DEADBEEF;
        @(negedge CLK);
        dev1 = 7'h1A; reg1 = 16'h1234; dat1 = 32'hDEADBEEF; start1 = 1'b1;
        lat = 0;
        do begin
            @(negedge CLK);
            lat++;
            start1 = (lat == 300);
        end while (!done1 && lat < 5000);
        start1 = 1'b0;
        checkOutput("wideLatency", lat, 1029);
        checkOutput("wideBytes", byteCnt[1], 7);
        for (int k = 0; k < 7; k++)
            checkOutput($sformatf("wideByte%0d", k), {24'b0, cap[1][k]}, {24'b0, bigStream[55-8*k -: 8]});
        checkOutput("wideError", {31'b0, error1}, 32'd0);

        // Slave holds SCL low for 20 cycles starting in q2 of bit 3 of the address byte.
        applyStimulus(7'h1A, 8'h0F, 8'h55, -1, 17, 1'b0, lat);
`ifdef I2C_CLK_STRETCH_EN
        checkOutput("stretchLatency", lat, 134);
`else
        checkOutput("stretchLatency", lat, 114);
`endif
        checkOutput("stretchBytes", byteCnt[0], 3);
        checkOutput("stretchByte0", {24'b0, cap[0][0]}, 32'h34);
        checkOutput("stretchByte2", {24'b0, cap[0][2]}, 32'h55);
        repeat (2) @(negedge CLK);

        // Reset in the middle of byte 1 (bit 2, q0, SDA driven low for the 0 bit of 0x0F).
        @(negedge CLK);
        dev0 = 7'h1A; reg0 = 8'h0F; dat0 = 8'h55; nackSel[0] = -1; start0 = 1'b1;
        @(negedge CLK);
        start0 = 1'b0;
        repeat (46) @(negedge CLK);
        checkOutput("midFrameOe", {30'b0, sclOe[0], sdaOe[0]}, 32'd3);
        rstN = 1'b0;
        #1;
        checkOutput("midRstOe", {30'b0, sclOe[0], sdaOe[0]}, 32'd0);
        checkOutput("midRstReady", {31'b0, ready0}, 32'd1);
        checkOutput("midRstDone", {31'b0, done0}, 32'd0);
        checkOutput("midRstError", {31'b0, error0}, 32'd0);
        @(negedge CLK);
        rstN = 1'b1;
        activity = 1'b0;
        repeat (20) begin
            @(negedge CLK);
            if (sclOe[0] || sdaOe[0] || !ready0 || done0) activity = 1'b1;
        end
        checkOutput("postRstQuiet", {31'b0, activity}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2c_burst_writer.md
# i2c_burst_writer

Parametrised I2C write master that replaces the fixed 24-bit single-register transmitter path. It sends one complete write transaction per request: START, device address with the write bit, 1–2 register-address bytes, 1–4 data bytes, then STOP. Both bus lines are open-drain. ACK is checked after every byte, and a NACK aborts the transaction with a reported byte index. The block sits between the codec/sensor configuration sequencer and the board I2C pads.

## Interface
- `REG_BYTES`, default 1: register-address bytes, legal values 1..2.
- `DATA_BYTES`, default 1: data bytes, legal values 1..4.
- `CLK_DIV`, default 1: CLK cycles per SCL quarter-period, minimum 1.
- `CLK`, input, 1: single clock; all logic is on its rising edge.
- `RESET_N`, input, 1: asynchronous, active-low reset.
- `START`, input, 1: transaction request, sampled only while READY=1.
- `DEV_ADDR`, input, 7: slave address.
- `REG_ADDR`, input, 8*REG_BYTES: register address, MSB byte sent first.
- `DATA`, input, 8*DATA_BYTES: payload, MSB byte sent first.
- `I2C_SDA_IN`, input, 1: SDA pad level.
- `I2C_SCL_IN`, input, 1: SCL pad level; used only when the clock-stretch option is compiled in.
- `I2C_SDA_OE`, output, 1: 1 = drive SDA low, 0 = release SDA.
- `I2C_SCL_OE`, output, 1: 1 = drive SCL low, 0 = release SCL.
- `READY`, output, 1: idle and accepting START.
- `DONE`, output, 1: one-cycle pulse when the STOP condition completes.
- `ERROR`, output, 1: NACK seen; holds until the next accepted START.
- `NACK_IDX`, output, 3: index of the NACKed byte (0 = address byte); valid while ERROR=1.

## Operation
- Frame: N = 1 + REG_BYTES + DATA_BYTES bytes. The first byte is {DEV_ADDR, 1'b0}. Every byte is sent MSB first.
- Accepting a request:
  - START=1 with READY=1 latches DEV_ADDR, REG_ADDR and DATA into a shift register.
  - READY drops on the next cycle, and ERROR and NACK_IDX clear on that same cycle.
  - START while READY=0 is ignored.
- State machine: IDLE → STRT → BIT (×8) → ACK → either BIT (next byte) or STOP → IDLE.
  - From ACK, a NACK goes directly to STOP.
  - After the Nth ACK, the machine goes to STOP.
- NACK handling:
  - NACK = SDA_IN sampled high at ACK sample time.
  - On NACK: ERROR=1 and NACK_IDX = current byte index.
  - The STOP condition is still generated, and DONE still pulses.
- Counters: a quarter counter (0..CLK_DIV-1) generates a tick; a 2-bit phase counter, a 3-bit bit counter and a byte counter (0..N-1) advance on ticks.
- Reset: any RESET_N low, including mid-frame, immediately gives OE=0 on both lines, READY=1, DONE=0, ERROR=0, NACK_IDX=0, and state IDLE. No STOP condition is generated.

## Timing
- One quarter = CLK_DIV CLK cycles. Line levels below are quarter by quarter.
- STRT, 2 quarters:
  - q0: SDA released, SCL released.
  - q1: SDA low, SCL released.
- BIT and ACK, 4 quarters each:
  - q0: SCL low; SDA updated to the bit value (released for ACK).
  - q1: SCL low.
  - q2: SCL released.
  - q3: SCL released.
  - SDA is sampled on the first CLK of q3.
- STOP, 3 quarters:
  - q0: SCL low, SDA low.
  - q1: SCL released, SDA low.
  - q2: both released.
- Latency from the START-accept edge to the DONE pulse: (5 + 36·N)·CLK_DIV + 1 CLK cycles for a full frame.
  - Example: N=3, CLK_DIV=1 gives 114 cycles.
- READY returns to 1 in the same cycle DONE pulses. A START in that cycle is accepted, so back-to-back frames are legal.
- SDA changes only while SCL is driven low, except the START and STOP edges.

## Configuration
- `I2C_CLK_STRETCH_EN` defined:
  - In BIT/ACK q2 and STOP q1, the quarter counter holds while SCL_OE=0 and I2C_SCL_IN=0 (slave stretching).
  - The stall is unbounded.
  - Latency grows by the number of stretched cycles.
- `I2C_CLK_STRETCH_EN` undefined:
  - I2C_SCL_IN is ignored.
  - Timing is exactly as stated in Timing.

## Test plan
- Reset values: RESET_N=0 mid-BIT of byte 1 → same cycle: SDA_OE=0, SCL_OE=0, READY=1. After release, no activity until START.
- Single write, default parameters, CLK_DIV=1: DEV_ADDR=7'h1A, REG=8'h0F, DATA=8'h55, slave ACKs all bytes → bit stream 0x34, 0x0F, 0x55. DONE arrives 114 cycles after accept. ERROR=0.
- REG_BYTES=2, DATA_BYTES=4, CLK_DIV=4, REG=16'h1234, DATA=32'hDEADBEEF, all ACKs → 7 bytes in order 0x34, 0x12, 0x34, 0xDE, 0xAD, 0xBE, 0xEF. Latency (5+252)·4+1 = 1029 cycles.
- Slave NACKs byte 2 (first data byte, default parameters) → STOP follows that ACK slot. ERROR=1, NACK_IDX=2. ERROR clears one cycle after the next accepted START.
- START held high continuously, N=3 → second frame accepted on the DONE cycle; STRT q0 begins the next cycle. START pulses while busy are ignored.
- With `I2C_CLK_STRETCH_EN`: force SCL_IN=0 for 20 cycles in the q2 of bit 3 → frame completes, DONE delayed by exactly 20 cycles. Without the macro, DONE is not delayed.
